neighbor_output_processor: RTL and testbench
============================================

NEIGHBOR_OUTPUT_PROCESSOR -- requirements
Module: neighbor_output_processor

Interface
REQ-001 Parameter TILE_SIZE, default 256, tile edge length; coordinate width CW = $clog2(TILE_SIZE).
REQ-002 Parameter IN_LANES, default 8, halo entries offered per cycle by the multiplier array.
REQ-003 Parameter FIFO_DEPTH, default 32, power of two, >= 2*IN_LANES; entry = {value[7:0], row[CW-1:0], column[CW-1:0]}.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 halo_value[IN_LANES]  input  8 each  out-of-tile product values.
REQ-007 halo_row[IN_LANES], halo_column[IN_LANES]  input  CW each  destination coordinates in the neighbor tile's frame.
REQ-008 halo_valid[IN_LANES]  input  1 each  lane carries an entry; any lane pattern, gaps allowed.
REQ-009 halo_ready  output  1  free slots >= IN_LANES; combinational from registered count.
REQ-010 neighbor_stall  input  1  neighbor has leftover inputs; the beat presented this cycle is not consumed.
REQ-011 neighbor_output_value[8], neighbor_output_row[8], neighbor_output_column[8]  output  8/CW/CW each  registered outgoing beat.
REQ-012 neighbor_output_write_enable[8]  output  1 each  registered lane valid.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  entries queued, excluding the output register.
REQ-014 idle  output  1  fifo_count == 0 and no write_enable asserted.

Function
REQ-015 Push: on a posedge with halo_ready=1, valid lanes SHALL be compacted in ascending lane order and written at the tail; invalid lanes consume no slot.
REQ-016 halo_valid lanes presented while halo_ready=0 SHALL be ignored; the producer holds them.
REQ-017 Beat acceptance: the current beat is consumed when neighbor_stall=0 at the posedge, or when no write_enable is asserted.
REQ-018 On consumption the output register SHALL load k = min(fifo_count, 8) head entries: FIFO order into lanes 0..k-1, write_enable[0..k-1]=1, others 0.
REQ-019 With neighbor_stall=1 and any write_enable asserted, all outputs SHALL hold unchanged and no entry is popped.
REQ-020 Inactive lanes SHALL drive value/row/column 0.
REQ-021 Latency: an entry pushed at edge N SHALL appear on the outputs no earlier than edge N+1 (head ordering permitting); no same-edge bypass.
REQ-022 Push and pop on the same edge: fifo_count_next = fifo_count + pushed - popped; popped entries are taken from pre-push contents only.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH, guaranteed by halo_ready.
REQ-024 Entry ordering SHALL be strict FIFO across beats; no reordering by bank or coordinate.
REQ-025 Coordinates and values SHALL pass through unmodified.
REQ-026 Stall asserted for any number of cycles SHALL lose no entry and duplicate none.

Reset
REQ-027 While reset=1: pointers and fifo_count 0, all write_enable 0, all value/row/column 0; halo_ready=1 and idle=1.
REQ-028 Reset mid-operation SHALL discard queued and presented entries immediately (asynchronous); the first push after deassertion lands at FIFO slot 0.

Verification
REQ-029 Single entry: lane 3 valid (value 0x5A, row 4, column 7), stall=0 -> next edge lane 0 carries 0x5A/4/7 with write_enable=8'b00000001; then idle=1.
REQ-030 Compaction: lanes 1,4,6 valid with values 0x11,0x22,0x33 -> lanes 0,1,2 carry 0x11,0x22,0x33 in that order.
REQ-031 Burst: 8 valid lanes on 4 consecutive cycles, stall=0 -> 4 consecutive full beats in push order; fifo_count peaks <= 8.
REQ-032 Stall: neighbor_stall=1 for 5 cycles while a beat is presented -> outputs bit-identical throughout; after release, the next beat continues in sequence with no gap or duplicate.
REQ-033 Full: stall held, 8-lane pushes until halo_ready=0 -> fifo_count=32 (default), further valids ignored; release stall -> 4 full beats drain in order.
REQ-034 Reset mid-burst: assert reset with fifo_count=20 -> write_enable all 0 and fifo_count=0 before the next edge; a post-reset push emerges as first beat.

Source files
------------

// File: rtl/neighbor_output_processor.sv
// Collects out-of-tile halo products, compacts valid lanes into a FIFO and
// emits up to eight queued entries per beat toward the neighbouring tile.
module neighbor_output_processor #(
  parameter int TILE_SIZE  = 256,
  parameter int IN_LANES   = 8,
  parameter int FIFO_DEPTH = 32,
  localparam int CW   = $clog2(TILE_SIZE),
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_LANES-1:0][7:0]     halo_value,
  input  logic [IN_LANES-1:0][CW-1:0]  halo_row,
  input  logic [IN_LANES-1:0][CW-1:0]  halo_column,
  input  logic [IN_LANES-1:0]          halo_valid,
  output logic                         halo_ready,
  input  logic                         neighbor_stall,
  output logic [7:0][7:0]              neighbor_output_value,
  output logic [7:0][CW-1:0]           neighbor_output_row,
  output logic [7:0][CW-1:0]           neighbor_output_column,
  output logic [7:0]                   neighbor_output_write_enable,
  output logic [CNTW-1:0]              fifo_count,
  output logic                         idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OL = 8;

  typedef struct packed {
    logic [7:0]    value;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } entry_t;

  entry_t                   r_mem [FIFO_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [PW:0]              r_count;
  logic [OL-1:0][7:0]       r_val;
  logic [OL-1:0][CW-1:0]    r_row;
  logic [OL-1:0][CW-1:0]    r_col;
  logic [OL-1:0]            r_we;

  logic [IN_LANES-1:0][PW-1:0] w_slot;
  logic [PW:0]                 w_valid_n;
  logic [PW:0]                 w_push_n;
  logic [PW:0]                 w_pop_n;
  logic [OL-1:0]               w_take;
  entry_t                      w_head [OL];
  logic                        w_consume;

  assign halo_ready = ((PW+1)'(FIFO_DEPTH) - r_count) >= (PW+1)'(IN_LANES);
  assign w_consume  = !neighbor_stall || (r_we == '0);

  // Each valid lane writes at tail + number of valid lanes below it,
  // which compacts the presented beat without any slot gaps.
  always_comb begin
    w_valid_n = '0;
    for (int unsigned i = 0; i < IN_LANES; i++) begin
      w_slot[i] = r_wr_ptr + w_valid_n[PW-1:0];
      if (halo_valid[i]) w_valid_n = w_valid_n + (PW+1)'(1);
    end
    w_push_n = halo_ready ? w_valid_n : '0;

    if (!w_consume)                 w_pop_n = '0;
    else if (r_count > (PW+1)'(OL)) w_pop_n = (PW+1)'(OL);
    else                            w_pop_n = r_count;

    for (int unsigned j = 0; j < OL; j++) begin
      w_take[j] = (PW+1)'(j) < w_pop_n;
      w_head[j] = r_mem[r_rd_ptr + PW'(j)];
    end
  end

  always_ff @(posedge clk) begin
    if (halo_ready) begin
      for (int unsigned i = 0; i < IN_LANES; i++) begin
        if (halo_valid[i]) r_mem[w_slot[i]] <= {halo_value[i], halo_row[i], halo_column[i]};
      end
    end
  end

  // Heads are read from pre-edge memory/count, so same-edge pushes never bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_val    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_we     <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_n[PW-1:0];
      r_rd_ptr <= r_rd_ptr + w_pop_n[PW-1:0];
      r_count  <= r_count + w_push_n - w_pop_n;
      if (w_consume) begin
        for (int unsigned j = 0; j < OL; j++) begin
          r_val[j] <= w_take[j] ? w_head[j].value : '0;
          r_row[j] <= w_take[j] ? w_head[j].row   : '0;
          r_col[j] <= w_take[j] ? w_head[j].col   : '0;
        end
        r_we <= w_take;
      end
    end
  end

  assign neighbor_output_value        = r_val;
  assign neighbor_output_row          = r_row;
  assign neighbor_output_column       = r_col;
  assign neighbor_output_write_enable = r_we;
  assign fifo_count                   = r_count;
  assign idle                         = (r_count == '0) && (r_we == '0);

endmodule

// File: tb/tb_neighbor_output_processor.sv
// Scoreboard bench: driver queues expected entries on accepted pushes, a
// negedge monitor checks each new beat, stall holds and the queue depth.
module tb_neighbor_output_processor;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0][7:0]     halo_value;
  logic [7:0][7:0]     halo_row;
  logic [7:0][7:0]     halo_column;
  logic [7:0]          halo_valid;
  logic                halo_ready;
  logic                neighbor_stall;
  logic [7:0][7:0]     neighbor_output_value;
  logic [7:0][7:0]     neighbor_output_row;
  logic [7:0][7:0]     neighbor_output_column;
  logic [7:0]          neighbor_output_write_enable;
  logic [5:0]          fifo_count;
  logic                idle;

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] q [$];

  neighbor_output_processor #(.TILE_SIZE(256), .IN_LANES(8), .FIFO_DEPTH(32)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .halo_value                   (halo_value),
    .halo_row                     (halo_row),
    .halo_column                  (halo_column),
    .halo_valid                   (halo_valid),
    .halo_ready                   (halo_ready),
    .neighbor_stall               (neighbor_stall),
    .neighbor_output_value        (neighbor_output_value),
    .neighbor_output_row          (neighbor_output_row),
    .neighbor_output_column       (neighbor_output_column),
    .neighbor_output_write_enable (neighbor_output_write_enable),
    .fifo_count                   (fifo_count),
    .idle                         (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Samples ready before the edge; an accepted push is queued in lane order.
  task automatic step();
    logic rdy;
    @(negedge clk);
    rdy = halo_ready;
    @(posedge clk);
    if (rdy && !reset)
      for (int i = 0; i < 8; i++)
        if (halo_valid[i]) q.push_back({halo_value[i], halo_row[i], halo_column[i]});
    #1;
  endtask

  task automatic fill(input logic [7:0] mask, input logic [7:0] base);
    halo_valid = mask;
    for (int i = 0; i < 8; i++) begin
      halo_value[i]  = base + 8'(i);
      halo_row[i]    = 8'(i * 16) + base;
      halo_column[i] = ~(base + 8'(i));
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    halo_valid = '0;
    while ((q.size() != 0 || !idle) && n < 40) begin
      step();
      n++;
    end
    check(name, 256'(q.size()), 256'(0));
  endtask

  // Monitor
  logic [255:0] prev_snap;
  logic [7:0]   prev_we;
  logic         prev_stall;
  int           prev_qsize;
  initial begin
    logic [255:0] snap;
    logic [7:0]   exp_we;
    logic [23:0]  e;
    int           k;
    prev_snap = '0; prev_we = '0; prev_stall = 1'b0; prev_qsize = 0;
    forever begin
      @(negedge clk);
      snap = 256'({neighbor_output_value, neighbor_output_row, neighbor_output_column,
                   neighbor_output_write_enable});
      if (reset) begin
        prev_snap = '0; prev_we = '0; prev_stall = 1'b0; prev_qsize = 0;
        continue;
      end
      if (!prev_stall || prev_we == '0) begin
        k = (prev_qsize > 8) ? 8 : prev_qsize;
        exp_we = '0;
        for (int i = 0; i < k; i++) exp_we[i] = 1'b1;
        check("beat_we", 256'(neighbor_output_write_enable), 256'(exp_we));
        for (int j = 0; j < 8; j++) begin
          if (neighbor_output_write_enable[j]) begin
            if (q.size() == 0) check("beat_unexpected", 256'(1), 256'(0));
            else begin
              e = q.pop_front();
              check("beat_lane_data", 256'({neighbor_output_value[j], neighbor_output_row[j],
                                            neighbor_output_column[j]}), 256'(e));
            end
          end else if (neighbor_output_value[j] != 0 || neighbor_output_row[j] != 0 ||
                       neighbor_output_column[j] != 0) begin
            check("inactive_lane_zero", 256'({neighbor_output_value[j], neighbor_output_row[j],
                                              neighbor_output_column[j]}), 256'(0));
          end
        end
      end else begin
        check("stall_hold", snap, prev_snap);
      end
      check("fifo_count", 256'(fifo_count), 256'(q.size()));
      check("halo_ready", 256'(halo_ready), 256'((32 - q.size()) >= 8));
      check("idle", 256'(idle), 256'(q.size() == 0 && neighbor_output_write_enable == 0));
      prev_snap  = snap;
      prev_we    = neighbor_output_write_enable;
      prev_stall = neighbor_stall;
      prev_qsize = q.size();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Driver
  initial begin
    int peak;
    reset = 1'b1; neighbor_stall = 1'b0;
    halo_valid = '0; halo_value = '0; halo_row = '0; halo_column = '0;
    #12;
    check("rst_we",    256'(neighbor_output_write_enable), 256'(0));
    check("rst_count", 256'(fifo_count), 256'(0));
    check("rst_ready", 256'(halo_ready), 256'(1));
    check("rst_idle",  256'(idle), 256'(1));
    check("rst_value", 256'(neighbor_output_value), 256'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Single entry on lane 3
    halo_valid = 8'b0000_1000;
    halo_value[3] = 8'h5A; halo_row[3] = 8'd4; halo_column[3] = 8'd7;
    step();
    check("single_not_bypassed", 256'(neighbor_output_write_enable), 256'(0));
    halo_valid = '0;
    step();
    check("single_we",    256'(neighbor_output_write_enable), 256'(8'h01));
    check("single_lane0", 256'({neighbor_output_value[0], neighbor_output_row[0],
                                 neighbor_output_column[0]}), 256'(24'h5A_04_07));
    step();
    check("single_idle", 256'(idle), 256'(1));

    // Compaction of lanes 1,4,6
    halo_valid = 8'b0101_0010;
    halo_value[1] = 8'h11; halo_value[4] = 8'h22; halo_value[6] = 8'h33;
    step();
    halo_valid = '0;
    step();
    check("compact_we", 256'(neighbor_output_write_enable), 256'(8'h07));
    check("compact_vals", 256'({neighbor_output_value[2], neighbor_output_value[1],
                                 neighbor_output_value[0]}), 256'(24'h33_22_11));
    drain("compact_drain");

    // Burst: four full pushes, no stall
    peak = 0;
    for (int b = 0; b < 4; b++) begin
      fill(8'hFF, 8'(8'h20 + b * 8));
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    halo_valid = '0;
    check("burst_peak_le8", 256'(peak <= 8), 256'(1));
    drain("burst_drain");

    // Stall held five cycles over a presented beat
    neighbor_stall = 1'b1;
    fill(8'hFF, 8'h60); step();
    fill(8'hFF, 8'h70); step();
    halo_valid = '0;
    repeat (5) step();
    check("stall_count", 256'(fifo_count), 256'(8));
    neighbor_stall = 1'b0;
    drain("stall_drain");

    // Full: stalled pushes until ready drops
    neighbor_stall = 1'b1;
    for (int b = 0; b < 8 && halo_ready; b++) begin
      fill(8'hFF, 8'(8'h80 + b * 8));
      step();
    end
    check("full_count", 256'(fifo_count), 256'(32));
    check("full_ready", 256'(halo_ready), 256'(0));
    fill(8'hFF, 8'hE0);
    step();
    check("full_ignored", 256'(fifo_count), 256'(32));
    neighbor_stall = 1'b0;
    drain("full_drain");

    // Reset with 20 entries queued
    neighbor_stall = 1'b1;
    fill(8'hFF, 8'h10); step();
    fill(8'hFF, 8'h18); step();
    fill(8'hFF, 8'h28); step();
    fill(8'h0F, 8'h38); step();
    check("pre_reset_count", 256'(fifo_count), 256'(20));
    fill(8'hFF, 8'h48);
    reset = 1'b1;
    #1;
    check("midrst_we",    256'(neighbor_output_write_enable), 256'(0));
    check("midrst_count", 256'(fifo_count), 256'(0));
    check("midrst_idle",  256'(idle), 256'(1));
    q.delete();
    halo_valid = '0;
    neighbor_stall = 1'b0;
    @(negedge clk); @(posedge clk); #1 reset = 1'b0;
    halo_valid = 8'b0000_0100;
    halo_value[2] = 8'hC3; halo_row[2] = 8'd9; halo_column[2] = 8'd200;
    step();
    halo_valid = '0;
    step();
    check("post_rst_first", 256'({neighbor_output_value[0], neighbor_output_row[0],
                                   neighbor_output_column[0]}), 256'(24'hC3_09_C8));
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
